// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences LC-3 MAR/MDR accesses onto an async SRAM with CE/OE/WE strobes and WAIT_STATES access cycles.
// Clk/Reset: clock and sync active-high reset. MEM_REQ/R_W/MAR/MDR: request, direction, address and write data from the CPU.
// Data_to_CPU/R: read data and one-cycle ready pulse. SRAM_*: address, strobes and split DQ pad signals.
// Switches/HEX_out: memory-mapped I/O word, active only when MEM_MMIO_EN is defined; otherwise HEX_out is 0.
module mem_access_ctrl #(
  parameter int          WAIT_STATES = 2,
  parameter int          ADDR_W      = 20,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MEM_REQ,
  input  logic              R_W,
  input  logic [15:0]       MAR,
  input  logic [15:0]       MDR,
  output logic [15:0]       Data_to_CPU,
  output logic              R,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic [15:0]       SRAM_DQ_out,
  output logic              SRAM_DQ_oe,
  input  logic [15:0]       SRAM_DQ_in,
  input  logic [15:0]       Switches,
  output logic [15:0]       HEX_out
);
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, DONE, RELEASE} state_t;
  localparam int CW = WAIT_STATES > 1 ? $clog2(WAIT_STATES) : 1;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          rw_q;
`ifndef MEM_MMIO_EN
  logic unused_sw;
  assign unused_sw = ^{Switches, IO_ADDR};
  assign HEX_out = 16'h0000;
`endif
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rw_q        <= 1'b0;
      Data_to_CPU <= 16'h0000;
      R           <= 1'b0;
      SRAM_ADDR   <= '0;
      SRAM_CE_N   <= 1'b1;
      SRAM_OE_N   <= 1'b1;
      SRAM_WE_N   <= 1'b1;
      SRAM_DQ_out <= 16'h0000;
      SRAM_DQ_oe  <= 1'b0;
`ifdef MEM_MMIO_EN
      HEX_out     <= 16'h0000;
`endif
    end else begin
      case (state_q)
        IDLE: if (MEM_REQ) begin
          rw_q        <= R_W;
          SRAM_ADDR   <= ADDR_W'(MAR);
          SRAM_DQ_out <= MDR;
`ifdef MEM_MMIO_EN
          if (MAR == IO_ADDR) begin
            state_q <= DONE;
            R       <= 1'b1;
            if (R_W) HEX_out <= MDR;
            else Data_to_CPU <= Switches;
          end else
`endif
          begin
            state_q    <= SETUP;
            SRAM_CE_N  <= 1'b0;
            SRAM_OE_N  <= R_W;
            SRAM_DQ_oe <= R_W;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          cnt_q     <= CW'(WAIT_STATES - 1);
          SRAM_WE_N <= ~rw_q;
        end
        ACCESS: if (cnt_q == '0) begin
          state_q   <= DONE;
          R         <= 1'b1;
          SRAM_CE_N <= 1'b1;
          SRAM_OE_N <= 1'b1;
          SRAM_WE_N <= 1'b1;
          if (!rw_q) Data_to_CPU <= SRAM_DQ_in;
        end else cnt_q <= cnt_q - 1'b1;
        DONE: begin
          state_q    <= RELEASE;
          R          <= 1'b0;
          SRAM_DQ_oe <= 1'b0;
        end
        RELEASE: if (!MEM_REQ) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench driving three controllers (WAIT_STATES 2, 1, 4) against SRAM models
module tb_mem_access_ctrl;
  typedef struct {int lat; logic [15:0] data;} exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, req, rw;
  logic [15:0] mar, mdr, sw;
  logic [15:0] dat[3], dqo[3], dqi[3], hex[3];
  logic [19:0] addr[3];
  logic r[3], ce[3], oe[3], we[3], dqoe[3];
  exp_t sb[3][$];
  logic [15:0] shadow[4096];
  logic [15:0] last_rd, exp_hex;
  int vectors = 0, errors = 0;
  function automatic int wsn(input int i);
    return i == 0 ? 2 : (i == 1 ? 1 : 4);
  endfunction
  for (genvar g = 0; g < 3; g++) begin : u
    logic [15:0] mem[4096];
    initial begin
      for (int k = 0; k < 4096; k++) mem[k] = 16'h0000;
      mem[12'h030] = 16'hBEEF;
    end
    always @(posedge clk) if (!ce[g] && !we[g]) mem[addr[g][11:0]] <= dqo[g];
    assign dqi[g] = (!ce[g] && !oe[g]) ? mem[addr[g][11:0]] : 16'h0BAD;
    mem_access_ctrl #(.WAIT_STATES(g == 0 ? 2 : (g == 1 ? 1 : 4))) dut (
      .Clk(clk), .Reset(rst), .MEM_REQ(req), .R_W(rw), .MAR(mar), .MDR(mdr),
      .Data_to_CPU(dat[g]), .R(r[g]), .SRAM_ADDR(addr[g]), .SRAM_CE_N(ce[g]),
      .SRAM_OE_N(oe[g]), .SRAM_WE_N(we[g]), .SRAM_DQ_out(dqo[g]), .SRAM_DQ_oe(dqoe[g]),
      .SRAM_DQ_in(dqi[g]), .Switches(sw), .HEX_out(hex[g]));
  end
  task automatic check_idle_outputs(input string tag, input bit data_zero);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (ce[i] !== 1'b1 || oe[i] !== 1'b1 || we[i] !== 1'b1 || dqoe[i] !== 1'b0 || r[i] !== 1'b0 ||
          hex[i] !== 16'h0000 || (data_zero && dat[i] !== 16'h0000) || (data_zero && addr[i] !== 20'h0)) begin
        errors++;
        $display("FAIL %s u%0d: ce=%b oe=%b we=%b dqoe=%b r=%b data=%h hex=%h addr=%h, want 1 1 1 0 0 0000 0000 00000",
                 tag, i, ce[i], oe[i], we[i], dqoe[i], r[i], dat[i], hex[i], addr[i]);
      end
    end
  endtask
  task automatic access(input bit w, input logic [15:0] a, input logic [15:0] d, input int hold);
    exp_t e;
    logic [15:0] cem[3], oem[3], wem[3], dqm[3], span;
    int npulse[3];
    bit bad[3];
    bit io;
    io = 1'b0;
`ifdef MEM_MMIO_EN
    io = (a == 16'hFFFF);
`endif
    for (int i = 0; i < 3; i++) begin
      e.lat  = io ? 1 : 2 + wsn(i);
      e.data = w ? last_rd : (io ? sw : shadow[a[11:0]]);
      sb[i].push_back(e);
      cem[i] = '0; oem[i] = '0; wem[i] = '0; dqm[i] = '0; npulse[i] = 0; bad[i] = 1'b0;
    end
    if (!w) last_rd = io ? sw : shadow[a[11:0]];
    else if (io) exp_hex = d;
    else shadow[a[11:0]] = d;
    @(negedge clk);
    req = 1'b1; rw = w; mar = a; mdr = d;
    for (int c = 1; c <= hold; c++) begin
      @(negedge clk);
      if (c == 2) begin mar = ~a; mdr = ~d; rw = ~w; end
      for (int i = 0; i < 3; i++) begin
        cem[i][c] = !ce[i]; oem[i][c] = !oe[i]; wem[i][c] = !we[i]; dqm[i][c] = dqoe[i];
        if ((!oe[i] && !we[i]) || (dqoe[i] && !oe[i])) bad[i] = 1'b1;
        if (r[i]) begin
          npulse[i]++;
          vectors++;
          if (sb[i].size() == 0) begin
            errors++;
            $display("FAIL rpulse u%0d: unexpected R at cycle %0d, want no pulse", i, c);
          end else begin
            e = sb[i].pop_front();
            if (c != e.lat || dat[i] !== e.data) begin
              errors++;
              $display("FAIL resp u%0d: R at cycle %0d data %h, want cycle %0d data %h", i, c, dat[i], e.lat, e.data);
            end
          end
        end
      end
      if (c == 2 && w && !io) begin
        vectors++;
        if (dqo[0] !== d || addr[0] !== {4'h0, a} || dqoe[0] !== 1'b1) begin
          errors++;
          $display("FAIL wdrive: dq_out=%h addr=%h dq_oe=%b, want %h %h 1", dqo[0], addr[0], dqoe[0], d, {4'h0, a});
        end
      end
      if (c == hold) req = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      span = io ? 16'h0 : 16'(((1 << (wsn(i) + 1)) - 1) << 1);
      vectors++;
      if (npulse[i] != 1 || bad[i] || cem[i] !== span || oem[i] !== (w ? 16'h0 : span) ||
          wem[i] !== (w ? (span & ~16'h2) : 16'h0) ||
          dqm[i] !== ((w && !io) ? 16'(((1 << (wsn(i) + 2)) - 1) << 1) : 16'h0) || hex[i] !== exp_hex) begin
        errors++;
        $display("FAIL strobes u%0d a=%h w=%b: pulses=%0d overlap=%b ce=%h oe=%h we=%h dqoe=%h hex=%h, want 1 0 %h %h %h %h %h",
                 i, a, w, npulse[i], bad[i], cem[i], oem[i], wem[i], dqm[i], hex[i], span, w ? 16'h0 : span,
                 w ? (span & ~16'h2) : 16'h0, (w && !io) ? 16'(((1 << (wsn(i) + 2)) - 1) << 1) : 16'h0, exp_hex);
      end
    end
  endtask
  task automatic test_reset;
    rst = 1'b1; req = 1'b0; rw = 1'b0; mar = '0; mdr = '0; sw = 16'h0042;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset", 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("idle_no_req", 1'b1);
  endtask
  task automatic test_read;
    access(1'b0, 16'h0030, 16'h0000, 10);
  endtask
  task automatic test_write;
    access(1'b1, 16'h1234, 16'hA5A5, 10);
    access(1'b0, 16'h1234, 16'h0000, 7);
  endtask
  task automatic test_reset_mid;
    @(negedge clk);
    req = 1'b1; rw = 1'b0; mar = 16'h0030;
    repeat (3) @(negedge clk);
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_mid", 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) sb[i].delete();
    last_rd = 16'h0000;
    repeat (3) @(negedge clk);
    check_idle_outputs("after_reset_mid", 1'b1);
  endtask
  task automatic test_io;
    access(1'b1, 16'hFFFF, 16'h00C3, 7);
    access(1'b0, 16'hFFFF, 16'h0000, 7);
  endtask
  task automatic test_back_to_back;
    for (int n = 0; n < 8; n++)
      access(1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 7)), 16'($urandom), 7);
  endtask
  initial begin
    for (int k = 0; k < 4096; k++) shadow[k] = 16'h0000;
    shadow[12'h030] = 16'hBEEF;
    last_rd = 16'h0000;
    exp_hex = 16'h0000;
    test_reset;
    test_read;
    test_write;
    test_reset_mid;
    test_io;
    test_back_to_back;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
